// File: rtl/velocity_stream_pkg.sv
// rtl/velocity_stream_pkg.sv - shared state encoding and constants for velocity_stream_ctrl
// Contents: state_e (sequencer states), CNT_ADDR (memory word holding the particle count).
package velocity_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_REQ,
        CNT_WAIT,
        STREAM,
        FIN
    } state_e;

    localparam int CNT_ADDR = 0;

endpackage

// File: rtl/velocity_prefetch_fifo.sv
// rtl/velocity_prefetch_fifo.sv - synchronous prefetch FIFO holding {index, velocity} words
// Ports: clk, rst (sync, active-high), clr (sync flush), push/push_data (write side),
//        pop/pop_data (read side, pop_data shows the head), empty, count (occupancy).
module velocity_prefetch_fifo
#(
    parameter int WIDTH = 104,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A push into a full FIFO is only taken when the head leaves in the same cycle.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            buf_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = buf_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/velocity_stream_ctrl.sv
// rtl/velocity_stream_ctrl.sv - streams one cell's velocities out and writes the updates back
// Ports: clk, rst (sync, active-high); start/busy/done/cnt_err (control);
//        mem_address/mem_data/mem_rden/mem_wren/mem_q (single-port velocity memory);
//        out_valid/out_ready/out_data/out_idx (velocity stream to the motion update unit);
//        wb_valid/wb_ready/wb_data (updated velocities, in particle order).
module velocity_stream_ctrl
    import velocity_stream_pkg::*;
#(
    parameter int DATA_WIDTH     = 96,
    parameter int PARTICLE_NUM   = 220,
    parameter int ADDR_WIDTH     = 8,
    parameter int MEM_RD_LATENCY = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cnt_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int WW = $clog2(MEM_RD_LATENCY+1);
    localparam int FW = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] N_MAX = ADDR_WIDTH'(PARTICLE_NUM-1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   n_q, n_d;
    logic [ADDR_WIDTH-1:0]   wb_cnt_q, wb_cnt_d;
    // One extra bit so the pointer can step past N without wrapping back to a legal address.
    logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic                    cnt_err_q, cnt_err_d;
    logic [MEM_RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [ADDR_WIDTH-1:0]   rd_idx_q [MEM_RD_LATENCY];
    logic [ADDR_WIDTH-1:0]   rd_idx_d [MEM_RD_LATENCY];
    logic [CW-1:0]           fifo_count, in_flight;
    logic [CW:0]             credit_used;
    logic                    fifo_empty, rd_en, wr_en;
    logic [FW-1:0]           fifo_head;
    logic [ADDR_WIDTH-1:0]   cnt_word;

    assign cnt_word = mem_q[ADDR_WIDTH-1:0];

    // Read-return pipeline: tags each issued read with its address so the word lands in the
    // FIFO exactly MEM_RD_LATENCY cycles later, and counts reads still in flight.
    always_comb begin
        rd_vld_d[0] = rd_en;
        rd_idx_d[0] = rd_ptr_q[ADDR_WIDTH-1:0];
        for (int i = 1; i < MEM_RD_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_idx_d[i] = rd_idx_q[i-1];
        end
        in_flight = '0;
        for (int i = 0; i < MEM_RD_LATENCY; i++) begin
            in_flight = in_flight + CW'(rd_vld_q[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wb_cnt_d    = wb_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wait_d      = wait_q;
        cnt_err_d   = cnt_err_q;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        wb_ready    = 1'b0;
        // Buffered plus in-flight words; a read is only issued when its data is sure to fit.
        credit_used = {1'b0, fifo_count} + {1'b0, in_flight};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CNT_REQ;
                    cnt_err_d = 1'b0;
                    n_d       = '0;
                    wb_cnt_d  = '0;
                    rd_ptr_d  = (ADDR_WIDTH+1)'(1);
                    wait_d    = '0;
                end
            end
            CNT_REQ: begin
                mem_rden    = 1'b1;
                mem_address = ADDR_WIDTH'(CNT_ADDR);
                state_d     = CNT_WAIT;
            end
            CNT_WAIT: begin
                // Count is captured when it appears on mem_q; the decision uses the
                // registered (clamped) value one cycle later.
                if (wait_q == WW'(MEM_RD_LATENCY)) begin
                    state_d = (n_q == '0) ? FIN : STREAM;
                end else begin
                    wait_d = wait_q + WW'(1);
                    if (wait_q == WW'(MEM_RD_LATENCY-1)) begin
                        if (cnt_word > N_MAX) begin
                            n_d       = N_MAX;
                            cnt_err_d = 1'b1;
                        end else begin
                            n_d = cnt_word;
                        end
                    end
                end
            end
            STREAM: begin
                wb_ready = (wb_cnt_q < n_q);
                wr_en    = wb_ready && wb_valid;
                if (wr_en) begin
                    mem_wren    = 1'b1;
                    mem_address = wb_cnt_q + ADDR_WIDTH'(1);
                    mem_data    = wb_data;
                    wb_cnt_d    = wb_cnt_q + ADDR_WIDTH'(1);
                end else if ((rd_ptr_q <= {1'b0, n_q}) &&
                             (credit_used < (CW+1)'(FIFO_DEPTH))) begin
                    rd_en       = 1'b1;
                    mem_rden    = 1'b1;
                    mem_address = rd_ptr_q[ADDR_WIDTH-1:0];
                    rd_ptr_d    = rd_ptr_q + (ADDR_WIDTH+1)'(1);
                end
                if (wb_cnt_q == n_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            wb_cnt_q  <= '0;
            rd_ptr_q  <= '0;
            wait_q    <= '0;
            cnt_err_q <= 1'b0;
            rd_vld_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            wb_cnt_q  <= wb_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wait_q    <= wait_d;
            cnt_err_q <= cnt_err_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_idx_q <= rd_idx_d;
    end

    velocity_prefetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == FIN),
        .push      (rd_vld_q[MEM_RD_LATENCY-1]),
        .push_data ({rd_idx_q[MEM_RD_LATENCY-1], mem_q}),
        .pop       (out_valid && out_ready),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign out_idx   = out_valid ? fifo_head[FW-1:DATA_WIDTH] : '0;
    assign busy      = (state_q == CNT_REQ) || (state_q == CNT_WAIT) || (state_q == STREAM);
    assign done      = (state_q == FIN);
    assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_velocity_stream_ctrl.sv
// tb/tb_velocity_stream_ctrl.sv - self-checking bench for velocity_stream_ctrl
module tb_velocity_stream_ctrl;

    localparam int DW  = 96;
    localparam int PN  = 220;
    localparam int AW  = 8;
    localparam int LAT = 1;
    localparam int FD  = 4;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, cnt_err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data, mem_q;
    logic          mem_rden, mem_wren;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          wb_valid, wb_ready;
    logic [DW-1:0] wb_data;

    always #5 clk = ~clk;

    velocity_stream_ctrl #(
        .DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW),
        .MEM_RD_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .cnt_err(cnt_err),
        .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data)
    );

    // Environment: single-port memory with one cycle of read latency.
    logic [DW-1:0] mem      [PN];
    logic [DW-1:0] init_mem [PN];

    always @(posedge clk) begin
        if (mem_wren && int'(mem_address) < PN) mem[mem_address] = mem_data;
        if (mem_rden && int'(mem_address) < PN) mem_q <= mem[mem_address];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_exp, start_cyc, done_cyc, done_cnt, xfer_cnt, wr_cnt, hold_until;
    int snap_reads, stream_reads, mem_acc;
    int ready_pct, wb_pct, wb_delay;
    bit err_exp, in_pass, prev_stall;
    int rd_count [256];
    int wr_count [256];
    int pend_idx [$];
    int pend_due [$];
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Value the consumer hands back for particle i.
    function automatic logic [DW-1:0] wb_word(input int i);
        if (i < 1 || i >= PN) return '0;
        return init_mem[i] ^ {32'h5A5A_0000 + 32'(i), 32'hDEAD_BEEF, ~32'(i)};
    endfunction

    task automatic monitor();
        if (mem_rden || mem_wren) begin
            chk("rw_exclusive", 128'(mem_rden & mem_wren), 128'(0));
            mem_acc++;
        end
        if (mem_rden) begin
            rd_count[mem_address]++;
            if (mem_address != '0) stream_reads++;
        end
        if (mem_wren || (wb_valid && wb_ready))
            chk("wren_is_handshake", 128'(mem_wren), 128'(wb_valid && wb_ready));
        if (mem_wren) begin
            chk("wr_addr", 128'(mem_address), 128'(wr_cnt + 1));
            chk("wr_data", 128'(mem_data), 128'(wb_word(wr_cnt + 1)));
            chk("rd_before_wr", 128'(rd_count[mem_address] > 0), 128'(1));
            wr_count[mem_address]++;
            wr_cnt++;
        end
        if (wb_valid && wb_ready && pend_idx.size() > 0) begin
            void'(pend_idx.pop_front());
            void'(pend_due.pop_front());
        end
        if (prev_stall) begin
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_word", 128'({out_idx, out_data}), 128'({prev_idx, prev_data}));
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
        prev_idx   = out_idx;
        if (out_valid && out_ready) begin
            xfer_cnt++;
            chk("out_idx", 128'(out_idx), 128'(xfer_cnt));
            chk("out_data", 128'(out_data), 128'(xfer_cnt < PN ? init_mem[xfer_cnt] : '0));
            pend_idx.push_back(int'(out_idx));
            pend_due.push_back(cyc + wb_delay);
        end
        if (done) done_cnt++;
        if (in_pass && cyc == start_cyc + 1) chk("err_cleared", 128'(cnt_err), 128'(0));
        if (in_pass && cyc > start_cyc) begin
            chk("busy", 128'(busy), 128'(!done));
            if (done) begin
                in_pass  = 1'b0;
                done_cyc = cyc;
            end
        end
        if (cyc == hold_until) snap_reads = stream_reads;
    endtask

    task automatic drive();
        start     = 1'b0;
        out_ready = (cyc >= hold_until) && (int'($urandom_range(99)) < ready_pct);
        if (pend_idx.size() > 0 && pend_due[0] <= cyc && int'($urandom_range(99)) < wb_pct) begin
            wb_valid = 1'b1;
            wb_data  = wb_word(pend_idx[0]);
        end else begin
            wb_valid = 1'b0;
            wb_data  = '0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 128'({busy, done, cnt_err, mem_rden, mem_wren, mem_address,
                                  out_valid, out_idx, wb_ready}), 128'(0));
        chk({tag, "_data"}, 128'({mem_data, 32'h0}), 128'(0));
        chk({tag, "_out"}, 128'(out_data), 128'(0));
    endtask

    task automatic start_pass(input int raw, input int r_pct, input int w_pct,
                              input int wdel, input bit hold);
        logic [DW-1:0] w;
        n_exp   = (raw > PN - 1) ? PN - 1 : raw;
        err_exp = (raw > PN - 1);
        w = rand_word();
        w[AW-1:0] = AW'(raw);
        init_mem[0] = w;
        for (int i = 1; i < PN; i++) init_mem[i] = rand_word();
        for (int i = 0; i < PN; i++) mem[i] = init_mem[i];
        for (int i = 0; i < 256; i++) begin
            rd_count[i] = 0;
            wr_count[i] = 0;
        end
        xfer_cnt = 0; wr_cnt = 0; done_cnt = 0; stream_reads = 0; snap_reads = -1;
        pend_idx.delete();
        pend_due.delete();
        ready_pct = r_pct; wb_pct = w_pct; wb_delay = wdel;
        start_cyc  = cyc;
        done_cyc   = -1;
        in_pass    = 1'b1;
        hold_until = hold ? cyc + 20 : 0;
        if (hold) out_ready = 1'b0;
        start = 1'b1;
    endtask

    task automatic finish_pass(input bit check_lat);
        int budget;
        int bad;
        int exp_r, exp_w;
        logic [DW-1:0] exp_word;
        budget = 4000;
        while (in_pass && budget > 0) begin
            cycle();
            budget--;
        end
        chk("pass_timeout", 128'(in_pass), 128'(0));
        in_pass = 1'b0;
        repeat (3) cycle();
        chk("done_pulses", 128'(done_cnt), 128'(1));
        chk("xfers", 128'(xfer_cnt), 128'(n_exp));
        chk("writes", 128'(wr_cnt), 128'(n_exp));
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            exp_r = (a <= n_exp) ? 1 : 0;
            exp_w = (a >= 1 && a <= n_exp) ? 1 : 0;
            if (rd_count[a] != exp_r || wr_count[a] != exp_w) bad++;
        end
        chk("addr_access_once", 128'(bad), 128'(0));
        bad = 0;
        for (int i = 1; i < PN; i++) begin
            exp_word = (i <= n_exp) ? wb_word(i) : init_mem[i];
            if (mem[i] !== exp_word) bad++;
        end
        chk("mem_contents", 128'(bad), 128'(0));
        chk("cnt_err", 128'(cnt_err), 128'(err_exp));
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_out_valid", 128'(out_valid), 128'(0));
        if (check_lat) chk("done_latency", 128'(done_cyc - start_cyc), 128'(4));
        if (snap_reads >= 0) chk("reads_under_backpressure", 128'(snap_reads), 128'(FD));
        hold_until = 0;
    endtask

    initial begin
        int budget;
        int acc0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; wb_data = '0;
        ready_pct = 100; wb_pct = 100; wb_delay = 2; hold_until = 0;
        in_pass = 1'b0; prev_stall = 1'b0; mem_acc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        cycle();

        // Short pass, full-rate consumer returning each word two cycles later.
        start_pass(3, 100, 100, 2, 1'b0);
        finish_pass(1'b0);

        // Empty cell.
        start_pass(0, 100, 100, 2, 1'b0);
        finish_pass(1'b1);

        // Consumer stalls for 20 cycles: prefetch must stop at the buffer depth.
        start_pass(10, 100, 100, 1, 1'b1);
        finish_pass(1'b0);

        // Immediate write-backs collide with pending reads.
        start_pass(12, 100, 100, 0, 1'b0);
        finish_pass(1'b0);

        // Oversized count is clamped and flagged.
        start_pass(250, 70, 80, 1, 1'b0);
        finish_pass(1'b0);

        // Flag clears on the next accepted start.
        start_pass(7, 50, 50, 3, 1'b0);
        finish_pass(1'b0);

        // Reset after two of five write-backs.
        start_pass(5, 100, 100, 2, 1'b0);
        budget = 200;
        while (wr_cnt < 2 && budget > 0) begin
            cycle();
            budget--;
        end
        chk("rst_wait_timeout", 128'(wr_cnt >= 2), 128'(1));
        rst = 1'b1; wb_valid = 1'b0; wb_data = '0; out_ready = 1'b0;
        ready_pct = 0; in_pass = 1'b0;
        pend_idx.delete();
        pend_due.delete();
        cycle();
        check_all_zero("mid_reset");
        rst = 1'b0;
        pend_idx.delete();
        pend_due.delete();
        done_cnt = 0;
        acc0 = mem_acc;
        repeat (6) cycle();
        chk("post_rst_no_done", 128'(done_cnt), 128'(0));
        chk("post_rst_no_access", 128'(mem_acc - acc0), 128'(0));
        start_pass(5, 100, 100, 2, 1'b0);
        finish_pass(1'b0);

        // Randomized passes.
        for (int k = 0; k < 4; k++) begin
            start_pass(int'($urandom_range(1, 40)), int'($urandom_range(30, 100)),
                       int'($urandom_range(30, 100)), int'($urandom_range(0, 4)), 1'b0);
            finish_pass(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/velocity_stream_ctrl.md
Name: velocity_stream_ctrl

Overview:
Sequencer between one cell's velocity memory (single-port, {vz,vy,vx} words, particle count at address 0) and the motion update unit. On start it reads the cell's particle count, then streams each velocity word out under valid/ready with a small prefetch buffer. It accepts the updated velocities back in particle order and writes them into the same memory.

Parameters:
DATA_WIDTH, 96, velocity word width {vz,vy,vx}, 32 bits each
PARTICLE_NUM, 220, memory depth in words; maximum legal count is PARTICLE_NUM-1
ADDR_WIDTH, 8, memory address width
MEM_RD_LATENCY, 1, cycles from mem_rden to valid mem_q
FIFO_DEPTH, 4, prefetch buffer depth (power of 2, at least MEM_RD_LATENCY+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begin a pass over the cell
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last write-back is committed
cnt_err  out  1  sticky until next accepted start; count was clamped
mem_address  out  ADDR_WIDTH  memory address
mem_data  out  DATA_WIDTH  write data
mem_rden  out  1  read enable
mem_wren  out  1  write enable
mem_q  in  DATA_WIDTH  memory read data
out_valid  out  1  velocity word available
out_ready  in  1  consumer accepts
out_data  out  DATA_WIDTH  velocity {vz,vy,vx}
out_idx  out  ADDR_WIDTH  memory address of out_data (1..N)
wb_valid  in  1  updated velocity available
wb_ready  out  1  controller accepts write-back
wb_data  in  DATA_WIDTH  updated velocity, strictly in particle order

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0; cnt_err 0.
- States: IDLE -> CNT_REQ -> CNT_WAIT -> STREAM -> FIN -> IDLE.
- IDLE: start accepted only here. Start is ignored in all other states. An accepted start clears cnt_err.
- CNT_REQ: for 1 cycle, mem_rden=1 and mem_address=0.
- CNT_WAIT: waits MEM_RD_LATENCY cycles, then latches N = mem_q[ADDR_WIDTH-1:0]. Upper bits are ignored.
  - If N > PARTICLE_NUM-1: N = PARTICLE_NUM-1 and cnt_err=1.
  - If N==0: go to FIN. Otherwise go to STREAM.
- STREAM, reads:
  - A read of address rd_ptr (starting at 1) is issued when rd_ptr<=N, (FIFO occupancy + reads in flight) < FIFO_DEPTH, and no write is issued that cycle.
  - Data enters the FIFO MEM_RD_LATENCY cycles after its read. No data loss under any backpressure.
- STREAM, output: out_valid = FIFO not empty. A word transfers when out_valid and out_ready. out_data and out_idx hold stable while out_valid=1 and out_ready=0.
- STREAM, write-back:
  - wb_ready=1 throughout STREAM while wb_cnt<N.
  - On wb_valid and wb_ready, in the same cycle: mem_wren=1, mem_address=wb_cnt+1, mem_data=wb_data; wb_cnt increments.
  - A write has priority over a read; the read retries next cycle.
  - mem_rden and mem_wren are never both high.
- The consumer may hand back word i before word i+1 is read. Address i is always read before it is written, because the stream is in order.
- STREAM -> FIN when wb_cnt==N. FIN: done=1 for 1 cycle, busy=0, then IDLE.
- rst mid-operation: returns to IDLE next edge, FIFO flushed, no further memory access, no done pulse.
- Address counters are ADDR_WIDTH bits wide. Clamping guarantees no wrap.

Decomposition:
- Package velocity_stream_pkg: state enum (IDLE, CNT_REQ, CNT_WAIT, STREAM, FIN) and the localparam CNT_ADDR=0.
- Sub-module velocity_prefetch_fifo: synchronous FIFO, FIFO_DEPTH x (DATA_WIDTH+ADDR_WIDTH), with push/pop/empty/count, same clk/rst.
- Credit logic and the FSM stay in the top module.

Test Plan:
- Count word 3, velocities V1..V3, out_ready=1, wb loops back each word after 2 cycles -> out_idx 1,2,3 in order; writes to addresses 1,2,3 carry the returned data; one done pulse; cnt_err=0.
- Count 0 -> no out_valid, no mem_wren; done 4 cycles after start (MEM_RD_LATENCY=1); busy high in between.
- N=10, out_ready held low 20 cycles -> exactly FIFO_DEPTH reads issued; out_data stable; after release all 10 delivered in order, no duplicates.
- wb_valid asserted in the same cycles a read is pending -> mem_wren wins; mem_rden/mem_wren never both 1; every address 1..N read once and written once.
- Count word 250 with PARTICLE_NUM=220 -> N=219, cnt_err=1, 219 words streamed; cnt_err clears on the next start.
- rst asserted after 2 of 5 write-backs -> next cycle all outputs 0, state IDLE, no done; a new start then runs a full pass correctly.
